// File: rtl/set_job_scheduler.sv
// Job FIFO and launch/wait sequencer in front of the SET engine.
// Optional WAIT watchdog abort: define SET_SCHED_WDT_EN.
module set_job_scheduler #(
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int WDT_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [23:0]      job_central,
    input  logic [11:0]      job_radius,
    input  logic [1:0]       job_mode,
    input  logic [TAG_W-1:0] job_tag,
    output logic             set_en,
    output logic [23:0]      set_central,
    output logic [11:0]      set_radius,
    output logic [1:0]       set_mode,
    input  logic             set_busy,
    input  logic             set_valid,
    input  logic [7:0]       set_candidate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_candidate,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [23:0]      r_q_central [DEPTH];
    logic [11:0]      r_q_radius  [DEPTH];
    logic [1:0]       r_q_mode    [DEPTH];
    logic [TAG_W-1:0] r_q_tag     [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;

    logic             r_set_en;
    logic [23:0]      r_set_central;
    logic [11:0]      r_set_radius;
    logic [1:0]       r_set_mode;
    logic [TAG_W-1:0] r_tag;
    logic             r_res_valid;
    logic [7:0]       r_res_candidate;
    logic [TAG_W-1:0] r_res_tag;
    logic             r_res_err;

    logic w_push;
    logic w_launch;
    logic w_capture;
    logic w_abort;
    logic w_wdt_hit;

    assign job_ready = (r_count != CW'(DEPTH));
    assign w_push    = job_valid & job_ready;

`ifdef SET_SCHED_WDT_EN
    localparam int WW = $clog2(WDT_LIMIT + 1);
    logic [WW-1:0] r_wdt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdt <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_wdt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wdt <= r_wdt + 1'b1;
        end
    end

    // Fires on the WDT_LIMIT-th WAIT cycle without a done pulse.
    assign w_wdt_hit = (r_wdt == WW'(WDT_LIMIT - 1));
`else
    assign w_wdt_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_launch  = 1'b0;
        w_capture = 1'b0;
        w_abort   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && !set_busy &&
                    (!r_res_valid || res_ready)) begin
                    w_launch = 1'b1;
                    w_next   = S_LAUNCH;
                end
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (set_valid) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end else if (w_wdt_hit) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_central[i] <= '0;
                r_q_radius[i]  <= '0;
                r_q_mode[i]    <= '0;
                r_q_tag[i]     <= '0;
            end
            r_wr            <= '0;
            r_rd            <= '0;
            r_count         <= '0;
            r_set_en        <= 1'b0;
            r_set_central   <= '0;
            r_set_radius    <= '0;
            r_set_mode      <= '0;
            r_tag           <= '0;
            r_res_valid     <= 1'b0;
            r_res_candidate <= '0;
            r_res_tag       <= '0;
            r_res_err       <= 1'b0;
        end else begin
            if (w_push) begin
                r_q_central[r_wr] <= job_central;
                r_q_radius[r_wr]  <= job_radius;
                r_q_mode[r_wr]    <= job_mode;
                r_q_tag[r_wr]     <= job_tag;
                r_wr              <= r_wr + 1'b1;
            end
            if (w_launch) begin
                r_set_central <= r_q_central[r_rd];
                r_set_radius  <= r_q_radius[r_rd];
                r_set_mode    <= r_q_mode[r_rd];
                r_tag         <= r_q_tag[r_rd];
                r_rd          <= r_rd + 1'b1;
            end
            r_count  <= r_count + CW'(w_push) - CW'(w_launch);
            r_set_en <= w_launch;
            // A launch only happens once the result slot is free, so capture wins.
            if (w_capture || w_abort) begin
                r_res_valid     <= 1'b1;
                r_res_candidate <= w_capture ? set_candidate : 8'hFF;
                r_res_tag       <= r_tag;
                r_res_err       <= w_abort;
            end else if (r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign set_en        = r_set_en;
    assign set_central   = r_set_central;
    assign set_radius    = r_set_radius;
    assign set_mode      = r_set_mode;
    assign res_valid     = r_res_valid;
    assign res_candidate = r_res_candidate;
    assign res_tag       = r_res_tag;
    assign res_err       = r_res_err;
endmodule
